// File: rtl/potential_adder.sv
// potential_adder: membrane-potential update stage, placed after the decay unit.
//
// A time_step pulse in IDLE latches model, input_weight (I) and
// decayed_potential (v). The sequencer then evaluates one of three neuron
// models (LIF, Izhikevich, QLIF) or the reserved pass-through. In FIN the
// result is compared against VT, and final_potential/spike/done are registered.
// The model constants A, B, C, D, VT and U are stored in internal registers.
// In IDLE, a load strobe writes the register chosen by init_mode from the
// input_weight bus.
//
// Handshake: there is no ready signal. time_step is accepted only at an IDLE
// edge where load is low. Any time_step or load that arrives while busy is
// dropped. done is a one-cycle pulse, and spike is valid only while done is high.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   time_step          start pulse
//   input_weight       signed synaptic input / parameter load data
//   decayed_potential  signed decayed membrane potential
//   model              00 LIF, 01 Izhikevich, 10 QLIF, 11 reserved
//   init_mode          load select: 1 A, 2 B, 3 C, 4 D, 5 VT, 6 U
//   load               parameter write strobe
//   final_potential    updated potential, held until the next completion
//   done, spike        one-cycle completion pulse and spike flag
//   state_dbg          current sequencer state (debug observation)
//
// Build option: define ADDER_SAT_EN to make every 32-bit sum clamp on signed
// overflow. When it is undefined, sums wrap modulo 2^32.
module potential_adder #(
  parameter int FRAC   = 8,
  parameter int DEF_A  = 5,
  parameter int DEF_B  = 51,
  parameter int DEF_C  = -65,
  parameter int DEF_D  = 8,
  parameter int DEF_VT = 30,
  parameter int DEF_U  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               time_step,
  input  logic signed [31:0] input_weight,
  input  logic signed [31:0] decayed_potential,
  input  logic        [1:0]  model,
  input  logic        [2:0]  init_mode,
  input  logic               load,
  output logic signed [31:0] final_potential,
  output logic               done,
  output logic               spike,
  output logic        [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LIF   = 3'd1,
    IZ_SQ = 3'd2,
    IZ_V  = 3'd3,
    IZ_U  = 3'd4,
    Q_SQ  = 3'd5,
    Q_V   = 3'd6,
    FIN   = 3'd7
  } state_t;

  state_t state, state_n;

  logic signed [31:0] a_q, b_q, c_q, d_q, vt_q, u_q;
  logic        [1:0]  model_q;
  logic signed [31:0] v_q, i_q, sq_q, sum_q, un_q;

  logic signed [31:0] sq_t, iz_t, v5_t, lif_sum, iz_sum, q_sum;
  logic signed [31:0] bs_t, diff_t, un_t;
  logic               spike_c;

  assign state_dbg = state;

`ifdef ADDER_SAT_EN
  function automatic logic signed [39:0] ext40(input logic signed [31:0] x);
    return {{8{x[31]}}, x};
  endfunction

  // Clamp a wide sum to the signed 32-bit range.
  function automatic logic signed [31:0] sat40(input logic signed [39:0] x);
    if (x > $signed(40'h007FFFFFFF))      return 32'sh7FFFFFFF;
    else if (x < $signed(40'hFF80000000)) return 32'sh80000000;
    else                                  return x[31:0];
  endfunction
`endif

  // Sequencer
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (time_step && !load) begin
          case (model)
            2'b00:   state_n = LIF;
            2'b01:   state_n = IZ_SQ;
            2'b10:   state_n = Q_SQ;
            default: state_n = FIN;
          endcase
        end
      end
      LIF:     state_n = FIN;
      IZ_SQ:   state_n = IZ_V;
      IZ_V:    state_n = IZ_U;
      IZ_U:    state_n = FIN;
      Q_SQ:    state_n = Q_V;
      Q_V:     state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Arithmetic. Only the low 32 bits of each product are kept. Those bits are
  // the same as the low half of the full 64-bit signed product, so a plain
  // 32-bit multiply gives the truncated result directly.
  always_comb begin
    sq_t   = v_q * v_q;
    iz_t   = (sq_q * 32'sd41) >>> 10;
    v5_t   = v_q * 32'sd5;
`ifdef ADDER_SAT_EN
    lif_sum = sat40(ext40(v_q) + ext40(i_q));
    iz_sum  = sat40(ext40(v_q) + ext40(iz_t) + ext40(v5_t) + 40'sd140
                    - ext40(u_q) + ext40(i_q));
    q_sum   = sat40(ext40(v_q) + ext40(sq_q >>> FRAC) + ext40(i_q));
`else
    lif_sum = v_q + i_q;
    iz_sum  = v_q + iz_t + v5_t + 32'sd140 - u_q + i_q;
    q_sum   = v_q + (sq_q >>> FRAC) + i_q;
`endif
    bs_t   = (b_q * sum_q) >>> FRAC;
    diff_t = bs_t - u_q;
    un_t   = u_q + ((a_q * diff_t) >>> FRAC);
    // The reserved model only passes v through and can never spike.
    spike_c = (model_q != 2'b11) && (sum_q >= vt_q);
  end

  // Datapath and parameter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      final_potential <= '0;
      done            <= 1'b0;
      spike           <= 1'b0;
      a_q             <= DEF_A;
      b_q             <= DEF_B;
      c_q             <= DEF_C;
      d_q             <= DEF_D;
      vt_q            <= DEF_VT;
      u_q             <= DEF_U;
      model_q         <= 2'b00;
      v_q             <= '0;
      i_q             <= '0;
      sq_q            <= '0;
      sum_q           <= '0;
      un_q            <= '0;
    end else begin
      done  <= 1'b0;
      spike <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            case (init_mode)
              3'b001:  a_q  <= input_weight;
              3'b010:  b_q  <= input_weight;
              3'b011:  c_q  <= input_weight;
              3'b100:  d_q  <= input_weight;
              3'b101:  vt_q <= input_weight;
              3'b110:  u_q  <= input_weight;
              default: ;
            endcase
          end else if (time_step) begin
            model_q <= model;
            v_q     <= decayed_potential;
            i_q     <= input_weight;
            sum_q   <= decayed_potential;  // result used by the reserved model
          end
        end
        LIF:   sum_q <= lif_sum;
        IZ_SQ: sq_q  <= sq_t;
        IZ_V:  sum_q <= iz_sum;
        IZ_U:  un_q  <= un_t;
        Q_SQ:  sq_q  <= sq_t;
        Q_V:   sum_q <= q_sum;
        FIN: begin
          done            <= 1'b1;
          spike           <= spike_c;
          final_potential <= spike_c ? c_q : sum_q;
          if (model_q == 2'b01) u_q <= spike_c ? (un_q + d_q) : un_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_potential_adder.sv
module tb_potential_adder;

  localparam int FRAC = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               time_step;
  logic signed [31:0] input_weight;
  logic signed [31:0] decayed_potential;
  logic        [1:0]  model;
  logic        [2:0]  init_mode;
  logic               load;
  logic signed [31:0] final_potential;
  logic               done;
  logic               spike;
  logic        [2:0]  state_dbg;

  potential_adder dut (
    .clk               (clk),
    .rst               (rst),
    .time_step         (time_step),
    .input_weight      (input_weight),
    .decayed_potential (decayed_potential),
    .model             (model),
    .init_mode         (init_mode),
    .load              (load),
    .final_potential   (final_potential),
    .done              (done),
    .spike             (spike),
    .state_dbg         (state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference parameter set
  int ma, mb, mc, md, mvt, mu;

  task automatic model_reset();
    ma = 5; mb = 51; mc = -65; md = 8; mvt = 30; mu = 0;
  endtask

  function automatic int fit(longint x);
`ifdef ADDER_SAT_EN
    if (x > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (x < -64'sd2147483648) return 32'h80000000;
`endif
    return int'(x);
  endfunction

  // Neuron-model equations written from the rules with plain integer maths.
  // For Izhikevich, this also advances the reference recovery variable.
  task automatic model_op(input logic [1:0] m, input int v, input int i,
                          output bit spk, output int fin, output int lat);
    int sum, sq, t, bs, diff, un;
    case (m)
      2'b00: begin
        sum = fit(longint'(v) + longint'(i));
        lat = 2;
      end
      2'b01: begin
        sq  = int'(longint'(v) * longint'(v));
        t   = int'(longint'(sq) * 41);
        t   = t >>> 10;
        sum = fit(longint'(v) + t + longint'(int'(5 * longint'(v))) + 140
                  - longint'(mu) + longint'(i));
        lat = 4;
      end
      2'b10: begin
        sq  = int'(longint'(v) * longint'(v));
        sum = fit(longint'(v) + longint'(sq >>> FRAC) + longint'(i));
        lat = 3;
      end
      default: begin
        sum = v;
        lat = 1;
      end
    endcase
    spk = (m != 2'b11) && (sum >= mvt);
    fin = spk ? mc : sum;
    if (m == 2'b01) begin
      bs   = int'(longint'(mb) * longint'(sum)) >>> FRAC;
      diff = bs - mu;
      un   = mu + (int'(longint'(ma) * longint'(diff)) >>> FRAC);
      mu   = spk ? un + md : un;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] sel, input int data);
    load = 1'b1; init_mode = sel; input_weight = data;
    tick();
    load = 1'b0; init_mode = 3'b000;
    case (sel)
      3'd1: ma = data;
      3'd2: mb = data;
      3'd3: mc = data;
      3'd4: md = data;
      3'd5: mvt = data;
      3'd6: mu = data;
      default: ;
    endcase
  endtask

  // Start one operation, wait (bounded) for done, and check the completion
  // cycle and the cycle after it. With disturb set, time_step and load
  // (VT <= 7) are pulsed on the first two busy cycles. Both must be ignored.
  task automatic run_op(input string tag, input logic [1:0] m, input int v,
                        input int i, input bit disturb);
    bit exp_spk;
    int exp_fin, exp_lat, cycles;
    bit got;
    model_op(m, v, i, exp_spk, exp_fin, exp_lat);
    model = m; decayed_potential = v; input_weight = i; time_step = 1'b1;
    tick();
    time_step = 1'b0;
    cycles = 0; got = 1'b0;
    while (!got && cycles < 10) begin
      if (disturb && cycles < 2) begin
        time_step = 1'b1; load = 1'b1; init_mode = 3'b101; input_weight = 7;
      end else begin
        time_step = 1'b0; load = 1'b0; init_mode = 3'b000;
      end
      tick();
      cycles++;
      if (done) got = 1'b1;
    end
    time_step = 1'b0; load = 1'b0; init_mode = 3'b000;
    check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_spike"}, {31'd0, spike}, {31'd0, exp_spk});
    check({tag, "_final"}, final_potential, exp_fin);
    tick();
    check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
    check({tag, "_spike_drop"}, {31'd0, spike}, 32'd0);
    check({tag, "_final_hold"}, final_potential, exp_fin);
    check({tag, "_idle"}, {29'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; time_step = 1'b0; load = 1'b0; init_mode = 3'b000;
    model = 2'b00; input_weight = '0; decayed_potential = '0;
    model_reset();
    tick(); tick();
    check("rst_final", final_potential, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_spike", {31'd0, spike}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    tick();

    // Load the test parameter set
    do_load(3'd1, 10); do_load(3'd2, 20); do_load(3'd3, 30);
    do_load(3'd4, 40); do_load(3'd5, 50); do_load(3'd6, 5);

    run_op("lif_basic", 2'b00, 25, 25, 1'b0);
    run_op("iz_basic", 2'b01, 35, 25, 1'b1);
    check("iz_u_reg", dut.u_q, 32'd46);
    check("iz_u_model", dut.u_q, mu);
    run_op("qlif_basic", 2'b10, 10, 30, 1'b0);

    // load wins over a simultaneous time_step
    load = 1'b1; init_mode = 3'b101; input_weight = 100; time_step = 1'b1;
    model = 2'b00; decayed_potential = 1;
    tick();
    load = 1'b0; time_step = 1'b0; init_mode = 3'b000; mvt = 100;
    for (int k = 0; k < 4; k++) begin
      check("ld_ts_done", {31'd0, done}, 32'd0);
      check("ld_ts_state", {29'd0, state_dbg}, 32'd0);
      tick();
    end
    run_op("vt100", 2'b00, 60, 30, 1'b0);

    // Reset in the middle of an Izhikevich run
    model = 2'b01; decayed_potential = 35; input_weight = 25; time_step = 1'b1;
    tick();
    time_step = 1'b0;
    tick();
    check("mid_state_iz_v", {29'd0, state_dbg}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("mid_rst_final", final_potential, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_spike", {31'd0, spike}, 32'd0);
    check("mid_rst_state", {29'd0, state_dbg}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mid_rst_no_done", {31'd0, done}, 32'd0);
    end
    check("def_a", dut.a_q, ma);
    check("def_b", dut.b_q, mb);
    check("def_c", dut.c_q, mc);
    check("def_d", dut.d_q, md);
    check("def_vt", dut.vt_q, mvt);
    check("def_u", dut.u_q, mu);
    run_op("lif_defaults", 2'b00, 25, 10, 1'b0);

    // Overflow boundary
    do_load(3'd5, 50);
    run_op("lif_ovf", 2'b00, 32'h7FFFFFF0, 32'h20, 1'b0);
    run_op("lif_ovf_neg", 2'b00, 32'h80000005, 32'hFFFFFF00, 1'b0);
    run_op("resv_hi", 2'b11, 1000, 3, 1'b0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      logic [1:0] m;
      int v, i;
      if ($urandom_range(0, 3) == 0) do_load(3'd5, int'($urandom_range(0, 300)) - 100);
      m = 2'($urandom_range(0, 3));
      case (m)
        2'b00: begin v = int'($urandom); i = int'($urandom); end
        2'b01: begin
          v = int'($urandom_range(0, 4000)) - 2000;
          i = int'($urandom_range(0, 2000)) - 1000;
        end
        2'b10: begin
          v = int'($urandom_range(0, 80000)) - 40000;
          i = int'($urandom_range(0, 2000000)) - 1000000;
        end
        default: begin v = int'($urandom_range(0, 400)) - 200; i = int'($urandom); end
      endcase
      run_op("rand", m, v, i, 1'b0);
    end
    check("rand_u_reg", dut.u_q, mu);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
